// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, DATA_BITS payload LSB first,
// optional odd/even parity, 1 or 2 stop bits) with a run-time baud divisor.
// Define UART_TX_BREAK_EN to add the tx_break_i port and the line-break state.
module uart_tx_param #(
   parameter int unsigned CLK_FREQ    = 50,
   parameter int unsigned UART_BPS    = 9600,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 1,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   input  logic [DATA_BITS-1:0] tx_data_i,
   input  logic [15:0]          baud_div_i,
`ifdef UART_TX_BREAK_EN
   input  logic                 tx_break_i,
`endif
   output logic                 tx_busy_o,
   output logic                 tx_done_o,
   output logic                 uart_txd_o
);

   localparam int unsigned BPS_DR    = CLK_FREQ * 1000000 / UART_BPS;
   localparam logic [15:0] BPS_DR_W  = 16'(BPS_DR);
   localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StParity, StStop
`ifdef UART_TX_BREAK_EN
      , StBreak
`endif
   } state_e;

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] data_q, data_d, data_sh;
   logic [15:0]          div_q, div_d, div_eff;
   logic [15:0]          cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic                 par_q, par_d;
   logic                 brk_q, brk_d;   // current STOP period is the mark after a break
   logic                 done_q, done_d;
   logic                 txd_q, txd_d;
   logic                 bit_end, accept;

   function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
      if (PARITY_MODE == 2) return ^d;
      if (PARITY_MODE == 1) return ~^d;
      return 1'b0;
   endfunction

   assign div_eff = (baud_div_i < 16'd2) ? BPS_DR_W : baud_div_i;
   assign bit_end = (cnt_q == div_q - 16'd1);
   assign accept  = tx_valid_i && tx_ready_o;

`ifdef UART_TX_BREAK_EN
   assign tx_ready_o = (state_q == StIdle) && !tx_break_i;
`else
   assign tx_ready_o = (state_q == StIdle);
`endif
   assign tx_busy_o  = (state_q != StIdle);
   assign tx_done_o  = done_q;
   assign uart_txd_o = txd_q;

   // Next-state logic: frame sequencing, baud and bit-index counters
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      div_d   = div_q;
      par_d   = par_q;
      idx_d   = idx_q;
      brk_d   = brk_q;
      done_d  = 1'b0;
      cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            idx_d = '0;
            brk_d = 1'b0;
`ifdef UART_TX_BREAK_EN
            if (tx_break_i) begin
               state_d = StBreak;
               div_d   = div_eff;
               brk_d   = 1'b1;
            end else
`endif
            if (accept) begin
               state_d = StStart;
               data_d  = tx_data_i;
               div_d   = div_eff;
               par_d   = calc_parity(tx_data_i);
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               idx_d   = '0;
            end
         end
         StData: begin
            if (bit_end) begin
               if (idx_q == LAST_DATA) begin
                  idx_d   = '0;
                  state_d = (PARITY_MODE != 0) ? StParity : StStop;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
               idx_d   = '0;
            end
         end
         StStop: begin
            if (bit_end) begin
               if (idx_q == LAST_STOP) begin
                  state_d = StIdle;
                  idx_d   = '0;
                  done_d  = !brk_q;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         StBreak: begin
            cnt_d = '0;
            idx_d = '0;
            if (!tx_break_i) state_d = StStop;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Line level for the state being entered, so uart_txd_o is registered with no lag
   always_comb begin
      data_sh = data_d >> idx_d;
      unique case (state_d)
         StStart:  txd_d = 1'b0;
         StData:   txd_d = data_sh[0];
         StParity: txd_d = par_d;
`ifdef UART_TX_BREAK_EN
         StBreak:  txd_d = 1'b0;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= StIdle;
         data_q  <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
         brk_q   <= 1'b0;
         done_q  <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
         brk_q   <= brk_d;
         done_q  <= done_d;
         txd_q   <= txd_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param using three parameterisations
// (8O1, 7E2, 8N1); the break scenario is built only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

   logic        clk;
   logic        rst_n;
   int          n_cmp;
   int          n_err;

   logic        valid0, ready0, busy0, done0, txd0;
   logic [7:0]  data0;
   logic [15:0] div0;
   logic        valid1, ready1, busy1, done1, txd1;
   logic [6:0]  data1;
   logic [15:0] div1;
   logic        valid2, ready2, busy2, done2, txd2;
   logic [7:0]  data2;
   logic [15:0] div2;
`ifdef UART_TX_BREAK_EN
   logic        break0;
`endif

   uart_tx_param #(
      .CLK_FREQ(50), .UART_BPS(9600), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)
   ) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .tx_valid_i(valid0), .tx_ready_o(ready0),
      .tx_data_i(data0), .baud_div_i(div0),
`ifdef UART_TX_BREAK_EN
      .tx_break_i(break0),
`endif
      .tx_busy_o(busy0), .tx_done_o(done0), .uart_txd_o(txd0)
   );

   uart_tx_param #(
      .CLK_FREQ(50), .UART_BPS(9600), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)
   ) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .tx_valid_i(valid1), .tx_ready_o(ready1),
      .tx_data_i(data1), .baud_div_i(div1),
`ifdef UART_TX_BREAK_EN
      .tx_break_i(1'b0),
`endif
      .tx_busy_o(busy1), .tx_done_o(done1), .uart_txd_o(txd1)
   );

   uart_tx_param #(
      .CLK_FREQ(50), .UART_BPS(9600), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
   ) u_dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .tx_valid_i(valid2), .tx_ready_o(ready2),
      .tx_data_i(data2), .baud_div_i(div2),
`ifdef UART_TX_BREAK_EN
      .tx_break_i(1'b0),
`endif
      .tx_busy_o(busy2), .tx_done_o(done2), .uart_txd_o(txd2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required finish before 2 ms");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (txd0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dut0 txd=%b ready=%b busy=%b done=%b required 1 1 0 0",
                  txd0, ready0, busy0, done0);
      end
      n_cmp++;
      if (txd1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dut1 txd=%b ready=%b busy=%b done=%b required 1 1 0 0",
                  txd1, ready1, busy1, done1);
      end
      n_cmp++;
      if (txd2 !== 1'b1 || ready2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dut2 txd=%b ready=%b busy=%b done=%b required 1 1 0 0",
                  txd2, ready2, busy2, done2);
      end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (txd0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset txd=%b ready=%b busy=%b required 1 1 0",
                  txd0, ready0, busy0);
      end
   endtask

   // 8O1, DIV=4, 0xA5; inputs changed mid-frame must not disturb it
   task automatic test_odd_8o1();
      logic exp_bits [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                             1'b1, 1'b1};
      valid0 = 1'b1;
      data0  = 8'hA5;
      div0   = 16'd4;
      tick();
      n_cmp++;
      if (busy0 !== 1'b1 || ready0 !== 1'b0) begin
         n_err++;
         $display("FAIL 8o1_accept busy=%b ready=%b required busy=1 ready=0", busy0, ready0);
      end
      valid0 = 1'b0;
      data0  = 8'h3C;
      div0   = 16'd9;
      for (int t = 0; t < 44; t++) begin
         n_cmp++;
         if (txd0 !== exp_bits[t/4] || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL 8o1_line t=%0d txd=%b done=%b required txd=%b done=0",
                     t, txd0, done0, exp_bits[t/4]);
         end
         tick();
      end
      n_cmp++;
      if (done0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0 || txd0 !== 1'b1) begin
         n_err++;
         $display("FAIL 8o1_done t=44 done=%b ready=%b busy=%b txd=%b required 1 1 0 1",
                  done0, ready0, busy0, txd0);
      end
      tick();
      n_cmp++;
      if (done0 !== 1'b0) begin
         n_err++;
         $display("FAIL 8o1_done_width done=%b required 0", done0);
      end
   endtask

   // 7E2, DIV=3, 0x7F: 33-cycle frame, ready low throughout
   task automatic test_even_7e2();
      logic exp_bits [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1};
      valid1 = 1'b1;
      data1  = 7'h7F;
      div1   = 16'd3;
      tick();
      valid1 = 1'b0;
      for (int t = 0; t < 33; t++) begin
         n_cmp++;
         if (txd1 !== exp_bits[t/3] || ready1 !== 1'b0 || done1 !== 1'b0) begin
            n_err++;
            $display("FAIL 7e2_line t=%0d txd=%b ready=%b done=%b required txd=%b ready=0 done=0",
                     t, txd1, ready1, done1, exp_bits[t/3]);
         end
         tick();
      end
      n_cmp++;
      if (done1 !== 1'b1 || ready1 !== 1'b1) begin
         n_err++;
         $display("FAIL 7e2_done t=33 done=%b ready=%b required 1 1", done1, ready1);
      end
   endtask

   // 8N1, DIV=4, 0x00 then 0xFF with valid held high
   task automatic test_back_to_back();
      int   acc;
      logic exp_txd;
      logic exp_done;
      valid2 = 1'b1;
      data2  = 8'h00;
      div2   = 16'd4;
      acc    = 1;
      tick();
      data2 = 8'hFF;
      for (int t = 0; t <= 81; t++) begin
         if (t < 40)       exp_txd = (t >= 36);
         else if (t == 40) exp_txd = 1'b1;
         else if (t < 81)  exp_txd = (t - 41 >= 4);
         else              exp_txd = 1'b1;
         exp_done = (t == 40) || (t == 81);
         n_cmp++;
         if (txd2 !== exp_txd || done2 !== exp_done) begin
            n_err++;
            $display("FAIL b2b_line t=%0d txd=%b done=%b required txd=%b done=%b",
                     t, txd2, done2, exp_txd, exp_done);
         end
         if (valid2 && ready2) acc++;
         if (t == 41) valid2 = 1'b0;
         tick();
      end
      n_cmp++;
      if (acc != 2) begin
         n_err++;
         $display("FAIL b2b_accepts got=%0d required 2", acc);
      end
   endtask

   // baud_div_i of 0 and 1 both fall back to 50 MHz / 9600 = 5208 clocks per bit
   task automatic test_default_divisor();
      int cnt;
      for (int k = 0; k < 2; k++) begin
         valid0 = 1'b1;
         data0  = 8'h55;
         div0   = 16'(k);
         tick();
         valid0 = 1'b0;
         div0   = 16'd4;
         cnt    = 0;
         while (txd0 === 1'b0 && cnt < 6000) begin
            cnt++;
            tick();
         end
         n_cmp++;
         if (cnt != 5208) begin
            n_err++;
            $display("FAIL default_div_%0d start_bit_cycles=%0d required 5208", k, cnt);
         end
         rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
         tick();
      end
   endtask

   // Reset during DATA bit 3, then a clean 0x3C frame at DIV=3
   task automatic test_reset_mid_frame();
      logic exp_bits [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b1};
      valid0 = 1'b1;
      data0  = 8'hA5;
      div0   = 16'd4;
      tick();
      valid0 = 1'b0;
      for (int t = 0; t < 17; t++) tick();
      n_cmp++;
      if (busy0 !== 1'b1) begin
         n_err++;
         $display("FAIL midframe_busy busy=%b required 1", busy0);
      end
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if (txd0 !== 1'b1 || busy0 !== 1'b0 || ready0 !== 1'b1 || done0 !== 1'b0) begin
         n_err++;
         $display("FAIL midframe_reset txd=%b busy=%b ready=%b done=%b required 1 0 1 0",
                  txd0, busy0, ready0, done0);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (done0 !== 1'b0 || txd0 !== 1'b1) begin
         n_err++;
         $display("FAIL midframe_release done=%b txd=%b required 0 1", done0, txd0);
      end
      valid0 = 1'b1;
      data0  = 8'h3C;
      div0   = 16'd3;
      tick();
      valid0 = 1'b0;
      for (int t = 0; t < 33; t++) begin
         n_cmp++;
         if (txd0 !== exp_bits[t/3] || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL refresh_line t=%0d txd=%b done=%b required txd=%b done=0",
                     t, txd0, done0, exp_bits[t/3]);
         end
         tick();
      end
      n_cmp++;
      if (done0 !== 1'b1) begin
         n_err++;
         $display("FAIL refresh_done t=33 done=%b required 1", done0);
      end
      tick();
   endtask

`ifdef UART_TX_BREAK_EN
   // Break for 50 cycles with a word pending, then 4-cycle mark, then the word goes out
   task automatic test_break();
      break0 = 1'b1;
      valid0 = 1'b1;
      data0  = 8'h81;
      div0   = 16'd4;
      tick();
      for (int i = 0; i < 50; i++) begin
         n_cmp++;
         if (txd0 !== 1'b0 || ready0 !== 1'b0 || busy0 !== 1'b1 || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL break_low i=%0d txd=%b ready=%b busy=%b done=%b required 0 0 1 0",
                     i, txd0, ready0, busy0, done0);
         end
         if (i == 49) break0 = 1'b0;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (txd0 !== 1'b1 || busy0 !== 1'b1 || ready0 !== 1'b0 || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL break_mark i=%0d txd=%b busy=%b ready=%b done=%b required 1 1 0 0",
                     i, txd0, busy0, ready0, done0);
         end
         tick();
      end
      n_cmp++;
      if (ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || txd0 !== 1'b1) begin
         n_err++;
         $display("FAIL break_idle ready=%b busy=%b done=%b txd=%b required 1 0 0 1",
                  ready0, busy0, done0, txd0);
      end
      tick();
      n_cmp++;
      if (txd0 !== 1'b0 || busy0 !== 1'b1) begin
         n_err++;
         $display("FAIL break_pending_accept txd=%b busy=%b required 0 1", txd0, busy0);
      end
      valid0 = 1'b0;
      for (int t = 0; t < 44; t++) tick();
      n_cmp++;
      if (done0 !== 1'b1) begin
         n_err++;
         $display("FAIL break_word_done done=%b required 1", done0);
      end
      tick();
   endtask
`endif

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      valid0 = 1'b0; data0 = '0; div0 = '0;
      valid1 = 1'b0; data1 = '0; div1 = '0;
      valid2 = 1'b0; data2 = '0; div2 = '0;
`ifdef UART_TX_BREAK_EN
      break0 = 1'b0;
`endif
      test_reset();
      test_odd_8o1();
      test_even_7e2();
      test_back_to_back();
      test_default_divisor();
      test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
      test_break();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
